// File: rtl/plotter_pkg.sv
// Shared types and default geometry for the plotter path.
// The plotter controller reuses DEF_COLS/DEF_ROWS for its line limits.
package plotter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 106;

endpackage

// File: rtl/plotter_pixel_sequencer_rise_detect.sv
// Registered rising-edge detector.
// The event is high for exactly one cycle per low-to-high transition of d.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end

    assign rise = d & ~q;

endmodule

// File: rtl/plotter_pixel_sequencer.sv
// Streams a thresholded frame-buffer image to the plotter, one pixel per
// rising edge of plotter_ready, in raster order.
module plotter_pixel_sequencer
    import plotter_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int ADDR_W   = 14,
    parameter int READ_LAT = 2
) (
    input  logic              clk_65mhz,
    input  logic              cpu_resetn,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    input  logic [7:0]        threshold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_rdata,
    input  logic              plotter_ready,
    input  logic              plotter_done,
    output logic              pixel_value,
    output logic              plotter_enable,
    output logic              busy,
    output logic              done,
    output logic [7:0]        row,
    output logic [7:0]        col
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t           state;
    logic [7:0]       thr_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       lat_cnt;
    logic             advance;
    logic             last_pixel;
    logic             proto_err;

    rise_detect u_ready_rise (
        .clk   (clk_65mhz),
        .rst_n (cpu_resetn),
        .d     (plotter_ready),
        .rise  (advance)
    );

    assign last_pixel = (col_q == COL_W'(COLS - 1)) && (row_q == ROW_W'(ROWS - 1));

    always_ff @(posedge clk_65mhz or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state       <= IDLE;
            thr_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lat_cnt     <= '0;
            mem_addr    <= '0;
            mem_en      <= 1'b0;
            pixel_value <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            if (abort) begin
                state       <= IDLE;
                pixel_value <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            thr_q    <= threshold;
                            col_q    <= '0;
                            row_q    <= '0;
                            mem_addr <= '0;
                            mem_en   <= 1'b1;
                            lat_cnt  <= '0;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (plotter_done) begin
                            state       <= DONE;
                            pixel_value <= 1'b0;
                        end else begin
                            // An edge here means the plotter ran ahead of us; it is dropped.
                            if (advance) proto_err <= 1'b1;
                            if (lat_cnt == 2'(READ_LAT)) begin
                                pixel_value <= (mem_rdata < thr_q);
                                state       <= PRESENT;
                            end else begin
                                lat_cnt <= lat_cnt + 2'd1;
                            end
                        end
                    end
                    PRESENT: begin
                        if (plotter_done) begin
                            state       <= DONE;
                            pixel_value <= 1'b0;
                        end else if (advance && !pause) begin
                            if (last_pixel) begin
                                state       <= DRAIN;
                                pixel_value <= 1'b0;
                            end else begin
                                if (col_q == COL_W'(COLS - 1)) begin
                                    col_q <= '0;
                                    row_q <= row_q + ROW_W'(1);
                                end else begin
                                    col_q <= col_q + COL_W'(1);
                                end
                                mem_addr <= mem_addr + ADDR_W'(1);
                                mem_en   <= 1'b1;
                                lat_cnt  <= '0;
                                state    <= FETCH;
                            end
                        end
                    end
                    DRAIN: begin
                        if (plotter_done) state <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Enable tracks pause combinationally so a pause takes effect the same cycle.
    assign plotter_enable = ((state == PRESENT) || (state == DRAIN)) && !pause;
    assign busy           = (state == FETCH) || (state == PRESENT) || (state == DRAIN);
    assign done           = (state == DONE);
    assign row            = 8'(row_q);
    assign col            = 8'(col_q);

endmodule

// File: doc/plotter_pixel_sequencer.md
Name: plotter_pixel_sequencer

Overview:
Sequences a stored binary image into the plotter controller, one pixel per handshake. It reads 8-bit grayscale pixels from a synchronous frame-buffer BRAM in raster order and thresholds each to 1 bit. It presents the result on the plotter's pixel input and advances on each rising edge of the plotter's ready strobe. It also gates the plotter enable (start/pause/abort) and reports progress and completion.

Parameters:
COLS, 80, pixels per plotted line
ROWS, 106, lines per image
ADDR_W, 14, frame-buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
READ_LAT, 2, BRAM read latency in cycles (1..3)

Ports:
clk_65mhz  input  1  system clock
cpu_resetn  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a drawing from pixel 0
pause  input  1  level; while high, plotter_enable is forced low and no advance occurs
abort  input  1  one-cycle pulse; return to IDLE, plotter_enable low
threshold  input  8  pixel is 1 when mem_rdata < threshold (dark = ink); latched at start
mem_addr  output  ADDR_W  frame-buffer read address
mem_en  output  1  read enable, one cycle per read
mem_rdata  input  8  read data, valid READ_LAT cycles after mem_en
plotter_ready  input  1  plotter's ready-next-pixel level (held many cycles)
plotter_done  input  1  plotter's drawing-done flag
pixel_value  output  1  current pixel to the plotter
plotter_enable  output  1  enable to the plotter
busy  output  1  high in any state other than IDLE/DONE
done  output  1  high in DONE
row  output  8  current line index
col  output  8  current column index

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, ready-edge register 0.
- Ready handshake: register plotter_ready each cycle; advance event = plotter_ready & ~ready_q. Level hold is not re-counted.
- States:
  - IDLE: on start, latch threshold, clear row/col, go FETCH.
  - FETCH: assert mem_en one cycle with mem_addr = row*COLS+col (registered; no multiplier, keep a running address counter). Wait READ_LAT cycles. Register pixel_value = (mem_rdata < thr_q). Go PRESENT.
  - PRESENT: plotter_enable = ~pause. On advance event with pause low:
    - if col == COLS-1 and row == ROWS-1, go DRAIN;
    - else col wraps to 0 at COLS-1 and row increments, otherwise col increments; address increments; go FETCH.
  - DRAIN: plotter_enable = ~pause; pixel_value forced 0. Wait for plotter_done, then go DONE.
  - DONE: done=1, plotter_enable=0. start restarts as from IDLE.
- plotter_done high in PRESENT or FETCH: go DONE immediately. The plotter reached its bottom boundary first; this is not an error.
- Advance event while in FETCH: is a protocol violation. Latch an internal sticky flag and ignore the event (not counted). Visible only to the bench via hierarchy.
- Advance event while pause is high: ignored and not deferred; the level is still high on unpause but its edge is gone.
- abort has priority over all events in the same cycle. start is ignored while busy.
- pixel_value changes only on a FETCH completion, at most READ_LAT+2 cycles after the advance event. This is far below one plotter step period.
- Width: address counter ADDR_W bits. row/col are zero-extended to 8 bits.

Decomposition:
- Shared package plotter_pkg: state enum (IDLE, FETCH, PRESENT, DRAIN, DONE) and default COLS/ROWS constants. The plotter controller reuses the constants for its line limits.
- One sub-module: rise_detect (1-bit registered edge detector, async active-low reset), used for plotter_ready.

Test Plan:
- Reset mid-PRESENT at row 3, col 10 -> next cycle all outputs 0, state IDLE; start afterwards fetches address 0.
- COLS=4, ROWS=2, BRAM ramp 0..7, threshold 4, ready pulses 8 times -> pixel_value sequence 1,1,1,1,0,0,0,0; mem_addr 0..7; after 8th edge DRAIN; plotter_done -> done=1.
- Hold plotter_ready high 1000 cycles -> exactly one advance (col 0->1).
- pause high, ready edge -> plotter_enable=0, col unchanged; pause low -> enable=1, still no advance.
- abort same cycle as ready edge -> IDLE, col unchanged, plotter_enable=0.
- plotter_done asserted at row 1, col 2 -> DONE next cycle, done=1, busy=0.
